con_dm_bridge: RTL and testbench

- Byte-command protocol engine that initiates accesses on the protocol-controller port of the data memory (con_write / con_addr / con_in / con_out).
- Accepts framed command bytes from a serial byte receiver and turns them into word writes and reads on that port.
- Returns read data and write acknowledgements as bytes to a serial byte transmitter.
- Runs on the ungated clock, so host access works while the core clock is gated.

---
 rtl/con_dm_bridge.sv | 162 ++++++++++++++++
 tb/tb_con_dm_bridge.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/con_dm_bridge.sv
// Byte-command bridge: framed serial commands become word reads/writes on the
// datamem protocol-controller port; read data and write acks return as bytes.
module con_dm_bridge #(
    parameter int unsigned ADDR_BITS  = 11,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 50000,
    parameter logic [7:0]  ACK_BYTE   = 8'h06
) (
    input  logic                  con_clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [3:0]            con_write,
    output logic [ADDR_BITS-1:0]  con_addr,
    output logic [DATA_WIDTH-1:0] con_in,
    input  logic [DATA_WIDTH-1:0] con_out,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        StIdle, StAddrHi, StAddrLo, StData, StWrite, StRdAddr, StRdCap, StTx, StAck
    } state_e;

    state_e                state_q, state_d;
    logic                  op_wr_q, op_wr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic                  err_q, err_d;
    logic                  timed_out;

    // Silence counted only while a frame is being received.
    assign timed_out = !rx_valid && (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        op_wr_d   = op_wr_q;
        cnt_d     = cnt_q;
        tmo_d     = '0;
        addr_d    = addr_q;
        din_d     = din_q;
        cap_d     = cap_q;
        err_d     = 1'b0;
        con_write = 4'h0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;

        if (state_q == StAddrHi || state_q == StAddrLo || state_q == StData) begin
            tmo_d = rx_valid ? '0 : tmo_q + TW'(1);
        end

        case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if (rx_data == 8'h57 || rx_data == 8'h52) begin
                        op_wr_d = (rx_data == 8'h57);
                        state_d = StAddrHi;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StAddrHi: begin
                if (rx_valid) begin
                    addr_d[ADDR_BITS-1:8] = rx_data[ADDR_BITS-9:0];
                    state_d = StAddrLo;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StAddrLo: begin
                if (rx_valid) begin
                    addr_d[7:0] = rx_data;
                    cnt_d       = 2'd0;
                    state_d     = op_wr_q ? StData : StRdAddr;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StData: begin
                if (rx_valid) begin
                    din_d[8*cnt_q +: 8] = rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = StWrite;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StWrite: begin
                con_write = 4'hF;
                err_d     = rx_valid;
                state_d   = StAck;
            end
            StRdAddr: begin
                // Memory samples con_addr at the end of this cycle.
                err_d   = rx_valid;
                state_d = StRdCap;
            end
            StRdCap: begin
                cap_d   = con_out;
                cnt_d   = 2'd0;
                err_d   = rx_valid;
                state_d = StTx;
            end
            StTx: begin
                tx_valid = 1'b1;
                tx_data  = cap_q[8*cnt_q +: 8];
                err_d    = rx_valid;
                if (tx_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = StIdle;
                end
            end
            StAck: begin
                tx_valid = 1'b1;
                tx_data  = ACK_BYTE;
                err_d    = rx_valid;
                if (tx_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge con_clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_wr_q <= 1'b0;
            cnt_q   <= 2'd0;
            tmo_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            cap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
        end
    end

    assign con_addr = addr_q;
    assign con_in   = din_q;
    assign err      = err_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_con_dm_bridge.sv
// Randomized bench for con_dm_bridge against a frame-level reference model,
// with a 1-cycle-latency datamem stand-in on the controller port.
module tb_con_dm_bridge;

    localparam int unsigned TMO = 40;

    logic        con_clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  con_write;
    logic [10:0] con_addr;
    logic [31:0] con_in;
    logic [31:0] con_out;
    logic        busy;
    logic        err;

    con_dm_bridge #(.TIMEOUT(TMO)) dut (
        .con_clk  (con_clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .con_write(con_write),
        .con_addr (con_addr),
        .con_in   (con_in),
        .con_out  (con_out),
        .busy     (busy),
        .err      (err)
    );

    always #5 con_clk = ~con_clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E3779B1 + 32'h13572468;
    endfunction

    // Datamem stand-in: read data appears the cycle after the address is sampled.
    logic [31:0] mem [0:2047];
    logic        mem_init;
    always @(posedge con_clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= init_word(i);
        end else if (con_write == 4'hF) begin
            mem[con_addr] <= con_in;
        end
        con_out <= mem[con_addr];
    end

    // Reference model state: the memory as the frame rules say it should be.
    logic [31:0] ref_mem [0:2047];

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor, sampled mid-cycle where inputs and outputs are settled.
    int          wr_n = 0;
    int          err_n = 0;
    int          stab_viol = 0;
    logic [3:0]  wr_we;
    logic [10:0] wr_addr;
    logic [31:0] wr_data;
    logic        hold_q = 1'b0;
    logic [7:0]  hold_d = 8'h00;
    logic [7:0]  act_tx [$];

    always @(negedge con_clk) begin
        if (!rst) begin
            if (con_write != 4'h0) begin
                wr_n    <= wr_n + 1;
                wr_we   <= con_write;
                wr_addr <= con_addr;
                wr_data <= con_in;
            end
            if (tx_valid && tx_ready) act_tx.push_back(tx_data);
            if (err) err_n <= err_n + 1;
            if (hold_q && (!tx_valid || tx_data != hold_d)) stab_viol <= stab_viol + 1;
            hold_q <= tx_valid && !tx_ready;
            hold_d <= tx_data;
        end
    end

    // 0: random, 1: one cycle in three, 2: held low, 3: always ready
    int rdy_mode = 3;
    initial begin
        int cyc = 0;
        tx_ready = 1'b0;
        forever begin
            @(posedge con_clk);
            #1;
            case (rdy_mode)
                0:       tx_ready = 1'($urandom_range(0, 1));
                1:       tx_ready = (cyc % 3 == 0);
                2:       tx_ready = 1'b0;
                default: tx_ready = 1'b1;
            endcase
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge con_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
        tick();
    endtask

    task automatic run_frame(input string tag, input logic is_wr, input logic [10:0] addr,
                             input logic [31:0] data, input int mode, input logic junk);
        logic [7:0]  frame [$];
        logic [7:0]  exp_tx [$];
        logic [31:0] w;
        logic [4:0]  hi_junk;
        int          base_wr;
        int          base_err;
        base_wr  = wr_n;
        base_err = err_n;
        act_tx.delete();
        rdy_mode = mode;
        hi_junk  = junk ? 5'($urandom) : 5'd0;

        if (is_wr) begin
            ref_mem[addr] = data;
            exp_tx.push_back(8'h06);
        end else begin
            w = ref_mem[addr];
            for (int b = 0; b < 4; b++) exp_tx.push_back(w[8*b +: 8]);
        end

        frame.push_back(is_wr ? 8'h57 : 8'h52);
        frame.push_back({hi_junk, addr[10:8]});
        frame.push_back(addr[7:0]);
        if (is_wr) for (int b = 0; b < 4; b++) frame.push_back(data[8*b +: 8]);
        foreach (frame[i]) send_byte(frame[i], $urandom_range(0, 3));
        wait_idle({tag, "_idle"});

        chk({tag, "_txlen"}, act_tx.size(), exp_tx.size());
        foreach (exp_tx[i]) begin
            if (i < act_tx.size()) chk({tag, "_txbyte"}, act_tx[i], exp_tx[i]);
        end
        chk({tag, "_nwrites"}, wr_n - base_wr, is_wr ? 1 : 0);
        if (is_wr) begin
            chk({tag, "_we"}, wr_we, 4'hF);
            chk({tag, "_waddr"}, wr_addr, addr);
            chk({tag, "_wdata"}, wr_data, data);
        end
        chk({tag, "_noerr"}, err_n - base_err, 0);
    endtask

    initial begin
        int base_err;
        int base_wr;
        int n;
        rst      = 1'b1;
        mem_init = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
        repeat (3) tick();

        chk("rst_busy", 32'(busy), 0);
        chk("rst_we", con_write, 0);
        chk("rst_addr", con_addr, 0);
        chk("rst_din", con_in, 0);
        chk("rst_txv", 32'(tx_valid), 0);
        chk("rst_txd", tx_data, 0);
        chk("rst_err", 32'(err), 0);
        mem_init = 1'b0;
        rst      = 1'b0;
        tick();

        run_frame("wr012", 1'b1, 11'h012, 32'hDEADBEEF, 3, 1'b0);
        run_frame("rd012", 1'b0, 11'h012, 32'h0, 3, 1'b0);
        run_frame("wr404", 1'b1, 11'h404, 32'h11223344, 3, 1'b0);
        base_n: begin
            n = stab_viol;
            run_frame("rd404_bp", 1'b0, 11'h404, 32'h0, 1, 1'b0);
            chk("tx_stable", stab_viol - n, 0);
        end

        // Bad opcode in IDLE
        base_err = err_n;
        send_byte(8'h41, 2);
        chk("badop_err", err_n - base_err, 1);
        chk("badop_busy", 32'(busy), 0);

        // Timeout after two bytes of a write frame
        base_err = err_n;
        base_wr  = wr_n;
        send_byte(8'h57, 0);
        send_byte(8'h00, 0);
        n = 0;
        while (!err && n < int'(TMO) + 5) begin
            tick();
            n++;
        end
        chk("tmo_err", 32'(err), 1);
        chk("tmo_len", 32'(n >= int'(TMO) - 1 && n <= int'(TMO) + 1), 1);
        tick();
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_nowr", wr_n - base_wr, 0);
        chk("tmo_errcnt", err_n - base_err, 1);

        // Overrun byte while TX is stalled
        act_tx.delete();
        rdy_mode = 2;
        send_byte(8'h52, 0);
        send_byte(8'h00, 0);
        send_byte(8'h30, 0);
        n = 0;
        while (!tx_valid && n < 20) begin
            tick();
            n++;
        end
        chk("ovr_txv", 32'(tx_valid), 1);
        base_err = err_n;
        send_byte(8'h55, 2);
        chk("ovr_err", err_n - base_err, 1);
        chk("ovr_busy", 32'(busy), 1);
        rdy_mode = 3;
        wait_idle("ovr_idle");
        chk("ovr_txlen", act_tx.size(), 4);
        for (int b = 0; b < 4; b++) begin
            logic [31:0] w;
            w = ref_mem[11'h030];
            if (b < act_tx.size()) chk("ovr_txbyte", act_tx[b], w[8*b +: 8]);
        end

        // Reset in the middle of the data bytes
        base_wr = wr_n;
        send_byte(8'h57, 0);
        send_byte(8'h00, 0);
        send_byte(8'h20, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b1;
        #1;
        chk("mrst_we", con_write, 0);
        chk("mrst_addr", con_addr, 0);
        chk("mrst_din", con_in, 0);
        chk("mrst_txv", 32'(tx_valid), 0);
        chk("mrst_busy", 32'(busy), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("mrst_nowr", wr_n - base_wr, 0);
        run_frame("rd020", 1'b0, 11'h020, 32'h0, 3, 1'b0);

        // Randomized frames, including the address extremes
        for (int i = 0; i < 40; i++) begin
            logic [10:0] a;
            case ($urandom_range(0, 5))
                0:       a = 11'h7FF;
                1:       a = 11'h000;
                2:       a = 11'h400 + 11'($urandom_range(0, 15));
                default: a = 11'($urandom);
            endcase
            run_frame("rand", 1'($urandom_range(0, 1)), a, $urandom, 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
